// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV64I core.
// Sequences FETCH/DECODE/EXEC/MEM/WB and owns the memory handshake.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_cond,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_is_fetch,
    output logic        ir_write,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_write,
    output logic [1:0]  wb_sel,
    output logic        instret,
    output logic        trap,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        WB     = 3'd4,
        TRAP   = 3'd5
    } state_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OPIMMW = 7'b0011011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPW    = 7'b0111011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(MEM_TIMEOUT - 1);

    state_t           st;
    state_t           st_nx;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       opc;
    logic             is_load;
    logic             is_store;
    logic             is_r;
    logic             is_i;
    logic             is_br;
    logic             is_jal;
    logic             is_jalr;
    logic             is_lui;
    logic             is_auipc;
    logic             legal;
    logic             to_hit;
    logic             unused_inst;

    assign opc         = inst[6:0];
    assign unused_inst = ^inst[31:7];

    assign is_load  = (opc == OPC_LOAD);
    assign is_store = (opc == OPC_STORE);
    assign is_r     = (opc == OPC_OP) || (opc == OPC_OPW);
    assign is_i     = (opc == OPC_OPIMM) || (opc == OPC_OPIMMW);
    assign is_br    = (opc == OPC_BRANCH);
    assign is_jal   = (opc == OPC_JAL);
    assign is_jalr  = (opc == OPC_JALR);
    assign is_lui   = (opc == OPC_LUI);
    assign is_auipc = (opc == OPC_AUIPC);

    assign legal = is_load | is_store | is_r | is_i | is_br |
                   is_jal | is_jalr | is_lui | is_auipc;

    // Final wait cycle: a miss here means the limit is reached.
    assign to_hit = (cnt == TO_LIM);
    assign state  = st;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st  <= FETCH;
            cnt <= '0;
        end else begin
            st <= st_nx;
            if (st_nx != st)
                cnt <= '0;
            else if (mem_req && !mem_ready)
                cnt <= cnt + 1'b1;
        end
    end

    always_comb begin
        st_nx        = st;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_is_fetch = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b00;
        alu_src_a    = 2'b00;
        alu_src_b    = 1'b0;
        alu_op       = 2'b00;
        reg_write    = 1'b0;
        wb_sel       = 2'b00;
        instret      = 1'b0;
        trap         = 1'b0;
        if (rst_n) begin
            unique case (st)
                FETCH: begin
                    mem_req      = 1'b1;
                    mem_is_fetch = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        st_nx    = DECODE;
                    end else if (to_hit) begin
                        st_nx = TRAP;
                    end
                end
                DECODE: st_nx = legal ? EXEC : TRAP;
                EXEC: begin
                    st_nx = WB;
                    unique case (1'b1)
                        is_r: alu_op = 2'b10;
                        is_i: begin
                            alu_src_b = 1'b1;
                            alu_op    = 2'b10;
                        end
                        is_load, is_store: begin
                            alu_src_b = 1'b1;
                            st_nx     = MEM;
                        end
                        is_lui: begin
                            alu_src_a = 2'b10;
                            alu_src_b = 1'b1;
                        end
                        is_auipc: begin
                            alu_src_a = 2'b01;
                            alu_src_b = 1'b1;
                        end
                        is_jalr: alu_src_b = 1'b1;
                        is_br: begin
                            alu_op   = 2'b01;
                            pc_write = 1'b1;
                            pc_src   = br_cond ? 2'b01 : 2'b00;
                            instret  = 1'b1;
                            st_nx    = FETCH;
                        end
                        is_jal: st_nx = WB;
                        default: st_nx = TRAP;
                    endcase
                end
                MEM: begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    if (mem_ready) begin
                        if (is_store) begin
                            pc_write = 1'b1;
                            instret  = 1'b1;
                            st_nx    = FETCH;
                        end else begin
                            st_nx = WB;
                        end
                    end else if (to_hit) begin
                        st_nx = TRAP;
                    end
                end
                WB: begin
                    reg_write = 1'b1;
                    pc_write  = 1'b1;
                    instret   = 1'b1;
                    st_nx     = FETCH;
                    if (is_load)
                        wb_sel = 2'b01;
                    else if (is_jal || is_jalr)
                        wb_sel = 2'b10;
                    if (is_jal)
                        pc_src = 2'b01;
                    else if (is_jalr)
                        pc_src = 2'b10;
                end
                TRAP: trap = 1'b1;
                default: st_nx = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomised bench for multicycle_ctrl against a per-instruction
// model of phases, latencies and control-line totals.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    localparam int K_LOAD  = 0;
    localparam int K_STORE = 1;
    localparam int K_BR    = 2;
    localparam int K_JAL   = 3;
    localparam int K_JALR  = 4;
    localparam int K_LUI   = 5;
    localparam int K_AUIPC = 6;
    localparam int K_R     = 7;
    localparam int K_I     = 8;
    localparam int K_ILL   = 9;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] inst = '0;
    logic        br_cond = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic        mem_is_fetch;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_op;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        instret;
    logic        trap;
    logic [2:0]  state;
    logic [15:0] outs;

    int total = 0;
    int bad = 0;

    logic [6:0] opcs [11] = '{
        7'b0000011, 7'b0010011, 7'b0011011, 7'b0110011,
        7'b0111011, 7'b0100011, 7'b1100011, 7'b1101111,
        7'b1100111, 7'b0110111, 7'b0010111
    };

    multicycle_ctrl #(
        .MEM_TIMEOUT(TO),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .inst(inst),
        .br_cond(br_cond),
        .mem_ready(mem_ready),
        .mem_req(mem_req),
        .mem_we(mem_we),
        .mem_is_fetch(mem_is_fetch),
        .ir_write(ir_write),
        .pc_write(pc_write),
        .pc_src(pc_src),
        .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b),
        .alu_op(alu_op),
        .reg_write(reg_write),
        .wb_sel(wb_sel),
        .instret(instret),
        .trap(trap),
        .state(state)
    );

    assign outs = {mem_req, mem_we, mem_is_fetch, ir_write, pc_write,
                   pc_src, alu_src_a, alu_src_b, alu_op, reg_write,
                   wb_sel, instret};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int cls_of(input logic [31:0] i);
        case (i[6:0])
            7'b0000011: return K_LOAD;
            7'b0100011: return K_STORE;
            7'b1100011: return K_BR;
            7'b1101111: return K_JAL;
            7'b1100111: return K_JALR;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            7'b0110011, 7'b0111011: return K_R;
            7'b0010011, 7'b0011011: return K_I;
            default: return K_ILL;
        endcase
    endfunction

    // Called at a falling edge; holds reset a few cycles.
    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rst_outs", {trap, outs}, 0);
            chk("rst_state", state, 0);
            @(negedge clk);
        end
        mem_ready = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst", {trap, state}, 0);
    endtask

    // Runs one instruction from FETCH; fw/mw are the memory wait
    // cycles before mem_ready for the fetch and data request.
    task automatic run_instr(input logic [31:0] ins, input logic br,
                             input int fw, input int mw);
        int k;
        int ex_st[$];
        bit ex_trap;
        int ex_fet, ex_mem, ex_pcs, ex_wbs, ex_a, ex_b, ex_op;
        int n, waited, tgt;
        int n_ret, n_pcw, n_rw, n_irw, n_req, n_we, n_fet, n_trp;
        int s_a, s_b, s_op, r_pcs, r_wbs;
        bit got_trap, done, saw_exec;

        k = cls_of(ins);
        ex_trap = 0;
        if (fw >= TO) begin
            repeat (TO) ex_st.push_back(0);
            ex_trap = 1;
        end else begin
            repeat (fw + 1) ex_st.push_back(0);
            ex_st.push_back(1);
            if (k == K_ILL) begin
                ex_trap = 1;
            end else begin
                ex_st.push_back(2);
                if (k == K_LOAD || k == K_STORE) begin
                    if (mw >= TO) begin
                        repeat (TO) ex_st.push_back(3);
                        ex_trap = 1;
                    end else begin
                        repeat (mw + 1) ex_st.push_back(3);
                        if (k == K_LOAD) ex_st.push_back(4);
                    end
                end else if (k != K_BR) begin
                    ex_st.push_back(4);
                end
            end
        end
        ex_fet = 0;
        ex_mem = 0;
        foreach (ex_st[j]) begin
            if (ex_st[j] == 0) ex_fet++;
            if (ex_st[j] == 3) ex_mem++;
        end
        ex_a  = (k == K_LUI) ? 2 : (k == K_AUIPC) ? 1 : 0;
        ex_b  = (k == K_R || k == K_BR || k == K_JAL) ? 0 : 1;
        ex_op = (k == K_R || k == K_I) ? 2 : (k == K_BR) ? 1 : 0;
        ex_pcs = (k == K_BR) ? int'(br) : (k == K_JAL) ? 1 :
                 (k == K_JALR) ? 2 : 0;
        ex_wbs = (k == K_LOAD) ? 1 :
                 (k == K_JAL || k == K_JALR) ? 2 : 0;

        inst = ins;
        br_cond = br;
        n = 0; waited = 0;
        n_ret = 0; n_pcw = 0; n_rw = 0; n_irw = 0;
        n_req = 0; n_we = 0; n_fet = 0; n_trp = 0;
        s_a = -1; s_b = -1; s_op = -1; r_pcs = -1; r_wbs = -1;
        got_trap = 0; done = 0; saw_exec = 0;
        while (!done) begin
            if (mem_req) begin
                tgt = mem_is_fetch ? fw : mw;
                mem_ready = (waited == tgt);
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            if (state == 3'd5) begin
                got_trap = 1;
                done = 1;
                chk("trap_outs", {trap, outs}, 32'h10000);
            end else begin
                if (n < ex_st.size())
                    chk("state_seq", state, ex_st[n]);
                n++;
                n_ret += int'(instret);
                n_pcw += int'(pc_write);
                n_rw  += int'(reg_write);
                n_irw += int'(ir_write);
                n_req += int'(mem_req);
                n_we  += int'(mem_we);
                n_fet += int'(mem_is_fetch);
                n_trp += int'(trap);
                if (state == 3'd2) begin
                    saw_exec = 1;
                    s_a = int'(alu_src_a);
                    s_b = int'(alu_src_b);
                    s_op = int'(alu_op);
                end
                if (instret) begin
                    r_pcs = int'(pc_src);
                    r_wbs = int'(wb_sel);
                    done = 1;
                end
                if (n >= 100) begin
                    chk("hang", n, ex_st.size());
                    done = 1;
                end
            end
            if (mem_ready && mem_req) waited = 0;
            else if (mem_req) waited++;
            @(negedge clk);
        end
        mem_ready = 1'b0;

        chk("cycles", n, ex_st.size());
        chk("trapped", got_trap, ex_trap);
        chk("instret", n_ret, ex_trap ? 0 : 1);
        chk("pc_write", n_pcw, ex_trap ? 0 : 1);
        chk("reg_write", n_rw,
            (ex_trap || k == K_BR || k == K_STORE) ? 0 : 1);
        chk("ir_write", n_irw, (fw < TO) ? 1 : 0);
        chk("mem_req", n_req, ex_fet + ex_mem);
        chk("mem_we", n_we, (k == K_STORE) ? ex_mem : 0);
        chk("mem_fetch", n_fet, ex_fet);
        chk("trap_early", n_trp, 0);
        if (fw < TO && k != K_ILL) begin
            chk("exec_seen", saw_exec, 1);
            chk("alu_a", s_a, ex_a);
            chk("alu_b", s_b, ex_b);
            chk("alu_op", s_op, ex_op);
        end
        if (!ex_trap) begin
            chk("pc_src", r_pcs, ex_pcs);
            if (k != K_BR && k != K_STORE)
                chk("wb_sel", r_wbs, ex_wbs);
        end
        chk("end_state", state, ex_trap ? 5 : 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, ins;
        logic [6:0]  opc;
        int          pick, fw, mw;

        @(negedge clk);
        do_reset();

        run_instr(32'h00500093, 1'b0, 0, 0);
        run_instr(32'h00500093, 1'b0, 2, 0);
        run_instr(32'h0000B083, 1'b0, 0, 3);
        run_instr(32'h00000063, 1'b1, 0, 0);
        run_instr(32'h00000063, 1'b0, 0, 0);
        run_instr(32'h000080E7, 1'b0, 0, 0);
        run_instr(32'h00113023, 1'b0, 0, 2);
        run_instr(32'h0000006F, 1'b0, 0, 0);

        run_instr(32'hFFFFFFFF, 1'b0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            chk("trap_hold", {state, trap, outs}, {3'd5, 1'b1, 16'd0});
            @(negedge clk);
        end
        do_reset();

        run_instr(32'h00500093, 1'b0, 200, 0);
        do_reset();
        run_instr(32'h00500093, 1'b0, TO, 0);
        do_reset();
        run_instr(32'h00500093, 1'b0, TO - 1, 0);
        run_instr(32'h0000B083, 1'b0, 0, TO - 1);
        run_instr(32'h00113023, 1'b0, 0, TO);
        do_reset();

        inst = 32'h0000B083;
        br_cond = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("mid_mem_state", state, 3);
        chk("mid_mem_req", mem_req, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_mem_req", mem_req, 0);
        chk("async_outs", {trap, outs}, 0);
        chk("async_state", state, 0);
        @(negedge clk);
        do_reset();
        run_instr(32'h00500093, 1'b0, 0, 0);

        for (int t = 0; t < 150; t++) begin
            r = $urandom;
            pick = $urandom_range(0, 11);
            if (pick < 11) begin
                ins = {r[31:7], opcs[pick]};
            end else begin
                do begin
                    opc = 7'($urandom);
                    ins = {r[31:7], opc};
                end while (cls_of(ins) != K_ILL);
            end
            fw = ($urandom_range(0, 19) == 0) ?
                 $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
            mw = ($urandom_range(0, 9) == 0) ?
                 $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 3);
            run_instr(ins, 1'($urandom_range(0, 1)), fw, mw);
            if (state == 3'd5)
                do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
